// File: rtl/mem_access_if.sv
// Load/store request, memory and response signals between the core, the access
// sequencer and the data memory. The sequencer uses the slave modport and its environment uses master.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_err, rsp_rdata, busy
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_err, rsp_rdata, busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer: checks alignment and funct3, issues a
// word-aligned memory request, waits for ack (with timeout) and returns extended data.
module mem_access_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

    state_t      r_state, w_next;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [7:0]  r_wait;

    logic        w_accept, w_illegal, w_misalign, w_timeout;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata, w_shift, w_ld_data;

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    assign w_timeout = (r_wait == 8'(MAX_WAIT - 1));

    // Legality is judged on the live request so the error decision is made at accept time
    always_comb begin
        w_illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                               : (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
        case (bus.req_funct3[1:0])
            2'b01:   w_misalign = bus.req_addr[0];
            2'b10:   w_misalign = |bus.req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (w_illegal || w_misalign) ? S_ERR : S_REQ;
            S_REQ: begin
                if (bus.mem_ack)    w_next = S_RESP;
                else if (w_timeout) w_next = S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_wait  <= 8'd0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_f3    <= bus.req_funct3;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == S_REQ && bus.mem_ack) r_rdata <= bus.mem_rdata;
            // Staying in REQ implies no ack this cycle; any exit clears the counter
            if (r_state == S_REQ && w_next == S_REQ) r_wait <= r_wait + 8'd1;
            else                                     r_wait <= 8'd0;
        end
    end

    always_comb begin
        case (r_f3[1:0])
            2'b00:   begin w_st_be = 4'b0001 << r_addr[1:0];            w_st_wdata = {4{r_wdata[7:0]}};  end
            2'b01:   begin w_st_be = r_addr[1] ? 4'b1100 : 4'b0011;     w_st_wdata = {2{r_wdata[15:0]}}; end
            default: begin w_st_be = 4'b1111;                           w_st_wdata = r_wdata;            end
        endcase
    end

    assign w_shift = r_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_ld_data = {24'd0, w_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_ld_data = {16'd0, w_shift[15:0]};
            default: w_ld_data = r_rdata;
        endcase
    end

    // Outputs decode the state register only, so reset clears them without waiting for a clock
    always_comb begin
        bus.req_ready = (r_state == S_IDLE);
        bus.busy      = (r_state != S_IDLE);
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_be    = 4'd0;
        bus.mem_wdata = 32'd0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = 32'd0;
        case (r_state)
            S_REQ: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_addr  = {r_addr[31:2], 2'b00};
                bus.mem_be    = r_we ? w_st_be : 4'b1111;
                bus.mem_wdata = w_st_wdata;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = r_we ? 32'd0 : w_ld_data;
            end
            S_ERR: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, timeout/reset sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_mem_access_ctrl;
    localparam int MAX_WAIT = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_access_if bus();

    mem_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwd;
        logic [31:0] exp_rrd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: access size in bytes from funct3, lanes and extension by plain arithmetic
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         output logic err, output logic [3:0] be,
                         output logic [31:0] mwd, output logic [31:0] rrd);
        int     size;
        int     off;
        bit     legal;
        longint v;
        longint span;
        size = 1 << f3[1:0];
        off  = int'(a % 4);
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err = !legal || (int'(a % 32'(size)) != 0);
        be  = we ? 4'(((1 << size) - 1) << off) : 4'hF;
        if (size == 1)      mwd = (wd % 256) * 32'h0101_0101;
        else if (size == 2) mwd = (wd % 65536) * 32'h0001_0001;
        else                mwd = wd;
        rrd = 32'd0;
        if (!we && !err) begin
            if (size == 4) rrd = rd;
            else begin
                span = longint'(1) << (8 * size);
                v = (longint'(rd) >> (8 * off)) % span;
                if (!f3[2] && v >= span / 2) v = v - span;
                rrd = 32'(v);
            end
        end
    endtask

    // dly>0: ack in the dly-th REQ cycle; dly==0: never ack (timeout expected)
    task automatic txn(input vec_t v, input string tag);
        int cycles;
        chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (v.exp_err && v.dly != 0) begin
            chk({tag, " no mem_req"}, 32'(bus.mem_req), 32'd0);
            chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd1);
            chk({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
        end else begin
            chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
            chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(v.we));
            chk({tag, " mem_addr"}, bus.mem_addr, v.addr & 32'hFFFF_FFFC);
            chk({tag, " mem_be"}, 32'(bus.mem_be), 32'(v.exp_be));
            if (v.we) chk({tag, " mem_wdata"}, bus.mem_wdata, v.exp_mwd);
            if (v.dly == 0) begin
                cycles = 0;
                while (bus.mem_req && cycles < 40) begin
                    cycles++;
                    @(posedge clk); #1;
                end
                chk({tag, " req cycles"}, 32'(cycles), 32'(MAX_WAIT));
                chk({tag, " tmo rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
                chk({tag, " tmo rsp_err"}, 32'(bus.rsp_err), 32'd1);
            end else begin
                repeat (v.dly - 1) begin
                    @(posedge clk); #1;
                    chk({tag, " mem_req held"}, 32'(bus.mem_req), 32'd1);
                end
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = v.rdata;
                @(posedge clk); #1;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
                chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
                chk({tag, " rsp_rdata"}, bus.rsp_rdata, v.exp_rrd);
                chk({tag, " mem_req drop"}, 32'(bus.mem_req), 32'd0);
            end
        end
        @(posedge clk); #1;
        chk({tag, " idle rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'd0;

        //          we    f3     addr          wdata          dly rdata          err   be       mwd            rrd
        tbl[0]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         1,  32'h80FF_0000, 1'b0, 4'hF,    32'h0,         32'hFFFF_FF80};
        tbl[1]  = '{1'b0, 3'd5, 32'h0000_0202, 32'h0,         2,  32'h8001_1234, 1'b0, 4'hF,    32'h0,         32'h0000_8001};
        tbl[2]  = '{1'b1, 3'd1, 32'h0000_0006, 32'hABCD_1234, 2,  32'h5555_5555, 1'b0, 4'b1100, 32'h1234_1234, 32'h0};
        tbl[3]  = '{1'b0, 3'd2, 32'h0000_000A, 32'h0,         1,  32'h0,         1'b1, 4'hF,    32'h0,         32'h0};
        tbl[4]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         1,  32'h0,         1'b1, 4'hF,    32'h0,         32'h0};
        tbl[5]  = '{1'b1, 3'd0, 32'h0000_0001, 32'h0000_0055, 1,  32'h0,         1'b0, 4'b0010, 32'h5555_5555, 32'h0};
        tbl[6]  = '{1'b1, 3'd2, 32'h0000_0008, 32'hDEAD_BEEF, 3,  32'h0,         1'b0, 4'hF,    32'hDEAD_BEEF, 32'h0};
        tbl[7]  = '{1'b0, 3'd1, 32'h0000_0003, 32'h0,         1,  32'h0,         1'b1, 4'hF,    32'h0,         32'h0};
        tbl[8]  = '{1'b1, 3'd4, 32'h0000_0000, 32'h0,         1,  32'h0,         1'b1, 4'hF,    32'h0,         32'h0};
        tbl[9]  = '{1'b0, 3'd4, 32'h0000_0101, 32'h0,         1,  32'h0000_9A00, 1'b0, 4'hF,    32'h0,         32'h0000_009A};
        tbl[10] = '{1'b0, 3'd1, 32'h0000_0000, 32'h0,         2,  32'h0000_8765, 1'b0, 4'hF,    32'h0,         32'hFFFF_8765};
        tbl[11] = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         15, 32'h1234_5678, 1'b0, 4'hF,    32'h0,         32'h1234_5678};

        #12;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset mem_req", 32'(bus.mem_req), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset mem_be", 32'(bus.mem_be), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) txn(tbl[i], $sformatf("vec%0d", i));

        // Timeout, then a late ack in IDLE must be ignored
        rv = '{1'b0, 3'd2, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0};
        txn(rv, "timeout");
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("late ack rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("late ack ready", 32'(bus.req_ready), 32'd1);

        // Reset in the middle of REQ
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h80;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre-reset mem_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid reset mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid reset ready", 32'(bus.req_ready), 32'd1);
        chk("mid reset busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        txn(tbl[0], "post-reset");

        for (int i = 0; i < 60; i++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.f3    = 3'($urandom_range(0, 7));
            rv.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.dly   = $urandom_range(1, 4);
            model(rv.we, rv.f3, rv.addr, rv.wdata, rv.rdata, rv.exp_err, rv.exp_be, rv.exp_mwd, rv.exp_rrd);
            txn(rv, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
